// File: rtl/instr_decode_hz.sv
// Hazard-aware MIPS decode stage: control decode, register file with optional
// write-through bypass, branch/jump targets, load-use stall and the ID/EX register.
module instr_decode_hz #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BYPASS         = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               instr,
  input  logic [DATA_WIDTH-1:0]     pc_plus_4,
  input  logic                      if_valid,
  input  logic                      reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]     reg_wr_data,
  input  logic                      hold_in,
  input  logic                      flush,
  output logic                      stall_out,
  output logic                      id_ex_valid,
  output logic                      id_ex_jump,
  output logic                      id_ex_branch,
  output logic                      id_ex_mem_to_reg_wr,
  output logic                      id_ex_mem_wr_en,
  output logic                      id_ex_alu_src_sel,
  output logic                      id_ex_reg_wr_en,
  output logic                      id_ex_illegal,
  output logic [2:0]                id_ex_alu_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_reg_wr_addr,
  output logic [DATA_WIDTH-1:0]     id_ex_reg_rd_data1,
  output logic [DATA_WIDTH-1:0]     id_ex_reg_rd_data2,
  output logic [DATA_WIDTH-1:0]     id_ex_sign_imm_ext,
  output logic [DATA_WIDTH-1:0]     id_ex_pc_branch,
  output logic [DATA_WIDTH-1:0]     id_ex_pc_jump,
  output logic [CNT_WIDTH-1:0]      bubble_cnt
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       mem_to_reg_wr;
    logic       mem_wr_en;
    logic       alu_src_sel;
    logic       reg_wr_en;
    logic       illegal;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic                      valid;
    ctrl_t                     ctrl;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     rd_data1;
    logic [DATA_WIDTH-1:0]     rd_data2;
    logic [DATA_WIDTH-1:0]     sign_imm_ext;
    logic [DATA_WIDTH-1:0]     pc_branch;
    logic [DATA_WIDTH-1:0]     pc_jump;
  } id_ex_t;

  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic [REG_ADDR_WIDTH-1:0] rs_a;
  logic [REG_ADDR_WIDTH-1:0] rt_a;
  logic [REG_ADDR_WIDTH-1:0] rd_a;
  ctrl_t                     dec;
  logic [REG_ADDR_WIDTH-1:0] dst;
  logic [DATA_WIDTH-1:0]     regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]     rd_data1;
  logic [DATA_WIDTH-1:0]     rd_data2;
  logic [DATA_WIDTH-1:0]     sign_imm_ext;
  logic                      lu;
  id_ex_t                    id_ex_d;
  id_ex_t                    id_ex_q;
  logic [CNT_WIDTH-1:0]      bubble_cnt_q;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs_a   = REG_ADDR_WIDTH'(instr[25:21]);
  assign rt_a   = REG_ADDR_WIDTH'(instr[20:16]);
  assign rd_a   = REG_ADDR_WIDTH'(instr[15:11]);

  always_comb begin
    // NOTE: defaults are assigned before the case so every path drives every
    // field; a path that left one unassigned would infer a latch.
    dec = '0;
    dst = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_wr_en = 1'b1;
        dst           = rd_a;
        case (funct)
          6'b100000: dec.alu_ctrl = 3'b010;
          6'b100010: dec.alu_ctrl = 3'b110;
          6'b100100: dec.alu_ctrl = 3'b000;
          6'b100101: dec.alu_ctrl = 3'b001;
          6'b101010: dec.alu_ctrl = 3'b111;
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
            dst         = '0;
          end
        endcase
      end
      OP_LW: begin
        dec.reg_wr_en     = 1'b1;
        dec.mem_to_reg_wr = 1'b1;
        dec.alu_src_sel   = 1'b1;
        dec.alu_ctrl      = 3'b010;
        dst               = rt_a;
      end
      OP_SW: begin
        dec.mem_wr_en   = 1'b1;
        dec.alu_src_sel = 1'b1;
        dec.alu_ctrl    = 3'b010;
      end
      OP_BEQ: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = 3'b110;
      end
      OP_ADDI: begin
        dec.reg_wr_en   = 1'b1;
        dec.alu_src_sel = 1'b1;
        dec.alu_ctrl    = 3'b010;
        dst             = rt_a;
      end
      OP_J:    dec.jump    = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // Register 0 is never stored; reads of it are forced to zero below.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is architecturally cleared on reset, so this
      // array gets a reset loop and maps to flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_wr_en && reg_wr_addr != '0) begin
      regs[reg_wr_addr] <= reg_wr_data;
    end
  end

  always_comb begin
    rd_data1 = regs[rs_a];
    rd_data2 = regs[rt_a];
    if (rs_a == '0)
      rd_data1 = '0;
    else if (BYPASS != 0 && reg_wr_en && reg_wr_addr == rs_a)
      rd_data1 = reg_wr_data;
    if (rt_a == '0)
      rd_data2 = '0;
    else if (BYPASS != 0 && reg_wr_en && reg_wr_addr == rt_a)
      rd_data2 = reg_wr_data;
  end

  assign sign_imm_ext = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};

  // A jump reads no registers, so it can never be held back by a pending load.
  assign lu = id_ex_q.valid && id_ex_q.ctrl.mem_to_reg_wr && (id_ex_q.wr_addr != '0)
              && if_valid && (opcode != OP_J)
              && ((id_ex_q.wr_addr == rs_a) || (id_ex_q.wr_addr == rt_a));

  assign stall_out = !flush && (hold_in || lu);

  always_comb begin
    id_ex_d              = '0;
    id_ex_d.valid        = if_valid;
    id_ex_d.ctrl         = if_valid ? dec : '0;
    id_ex_d.wr_addr      = if_valid ? dst : '0;
    id_ex_d.rs           = rs_a;
    id_ex_d.rt           = rt_a;
    id_ex_d.rd_data1     = rd_data1;
    id_ex_d.rd_data2     = rd_data2;
    id_ex_d.sign_imm_ext = sign_imm_ext;
    id_ex_d.pc_branch    = pc_plus_4 + (sign_imm_ext << 2);
    id_ex_d.pc_jump      = {pc_plus_4[DATA_WIDTH-1:28], instr[25:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      id_ex_q      <= '0;
      bubble_cnt_q <= '0;
    end else if (flush) begin
      id_ex_q <= '0;
    end else if (hold_in) begin
      id_ex_q <= id_ex_q;
    end else if (lu) begin
      id_ex_q <= '0;
      if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign id_ex_valid         = id_ex_q.valid;
  assign id_ex_jump          = id_ex_q.ctrl.jump;
  assign id_ex_branch        = id_ex_q.ctrl.branch;
  assign id_ex_mem_to_reg_wr = id_ex_q.ctrl.mem_to_reg_wr;
  assign id_ex_mem_wr_en     = id_ex_q.ctrl.mem_wr_en;
  assign id_ex_alu_src_sel   = id_ex_q.ctrl.alu_src_sel;
  assign id_ex_reg_wr_en     = id_ex_q.ctrl.reg_wr_en;
  assign id_ex_illegal       = id_ex_q.ctrl.illegal;
  assign id_ex_alu_ctrl      = id_ex_q.ctrl.alu_ctrl;
  assign id_ex_rs            = id_ex_q.rs;
  assign id_ex_rt            = id_ex_q.rt;
  assign id_ex_reg_wr_addr   = id_ex_q.wr_addr;
  assign id_ex_reg_rd_data1  = id_ex_q.rd_data1;
  assign id_ex_reg_rd_data2  = id_ex_q.rd_data2;
  assign id_ex_sign_imm_ext  = id_ex_q.sign_imm_ext;
  assign id_ex_pc_branch     = id_ex_q.pc_branch;
  assign id_ex_pc_jump       = id_ex_q.pc_jump;
  assign bubble_cnt          = bubble_cnt_q;

endmodule
